// File: rtl/huff_bit_packer_if.sv
// rtl/huff_bit_packer_if.sv - code input / packed word output bundle for huff_bit_packer
interface huff_bit_packer_if #(
    parameter int CODE_W = 27
);
    logic [CODE_W-1:0] in_code;
    logic [5:0]        in_len;
    logic              in_valid;
    logic              flush;
    logic              in_ready;
    logic [31:0]       dout;
    logic              dout_valid;
    logic              flush_done;

    modport master (
        output in_code, in_len, in_valid, flush,
        input  in_ready, dout, dout_valid, flush_done
    );

    modport slave (
        input  in_code, in_len, in_valid, flush,
        output in_ready, dout, dout_valid, flush_done
    );
endinterface

// File: rtl/huff_bit_packer.sv
// rtl/huff_bit_packer.sv - MSB-first Huffman bit packer into 32-bit words; BYTE_STUFF_EN adds 0xFF->0xFF,0x00 stuffing
module huff_bit_packer #(
    parameter int CODE_W = 27
) (
    input  logic             clk,
    input  logic             nrst,
    huff_bit_packer_if.slave bus
);

    typedef enum logic [2:0] {
        RUN,
`ifdef BYTE_STUFF_EN
        STUFF,
`endif
        PAD_BYTE,
        PAD_WORD,
        DONE
    } state_t;

    localparam logic [6:0]  FILL_MAX = 7'(64 - CODE_W);
    localparam logic [63:0] ONES     = {64{1'b1}};

    state_t      state;
    logic [63:0] bitbuf;
    logic [6:0]  bit_cnt;
    logic [1:0]  lane_cnt;
    logic [23:0] word;
    logic        flush_pend;
    logic [31:0] dout_r;
    logic        dout_valid_r;
    logic        flush_done_r;
`ifdef BYTE_STUFF_EN
    logic        stuff_pad;
`endif

    logic        ready_int;
    logic        extract;
    logic        accept;
    logic        flush_acc;
    logic        pend_eff;
    logic [6:0]  len_eff;
    logic [6:0]  cnt_post;
    logic [6:0]  cnt_next;
    logic [63:0] code_mask;
    logic [63:0] buf_next;
    logic [7:0]  pad_byte;
    logic        lane_wr;
    logic [7:0]  lane_byte;

    assign ready_int      = (state == RUN) && (bit_cnt <= FILL_MAX) && !flush_pend;
    assign bus.in_ready   = ready_int;
    assign bus.dout       = dout_r;
    assign bus.dout_valid = dout_valid_r;
    assign bus.flush_done = flush_done_r;

    // Extraction and append share a cycle: the new code lands behind what remains after the shift.
    always_comb begin
        extract   = (state == RUN) && (bit_cnt >= 7'd8);
        accept    = bus.in_valid && ready_int;
        flush_acc = bus.flush && ready_int;
        pend_eff  = flush_pend || flush_acc;
        len_eff   = accept ? {1'b0, bus.in_len} : 7'd0;
        cnt_post  = extract ? (bit_cnt - 7'd8) : bit_cnt;
        code_mask = 64'(bus.in_code) & (ONES >> (7'd64 - len_eff));
        buf_next  = (extract ? {bitbuf[55:0], 8'h00} : bitbuf)
                  | (code_mask << (7'd64 - cnt_post - len_eff));
        cnt_next  = cnt_post + len_eff;
        pad_byte  = bitbuf[63:56] | (8'hFF >> bit_cnt);
    end

    always_comb begin
        lane_wr   = 1'b0;
        lane_byte = 8'h00;
        case (state)
            RUN: begin
                lane_wr   = extract;
                lane_byte = bitbuf[63:56];
            end
`ifdef BYTE_STUFF_EN
            STUFF: begin
                lane_wr   = 1'b1;
                lane_byte = 8'h00;
            end
`endif
            PAD_BYTE: begin
                lane_wr   = 1'b1;
                lane_byte = pad_byte;
            end
            PAD_WORD: begin
                lane_wr   = 1'b1;
                lane_byte = 8'hFF;
            end
            default: begin
                lane_wr   = 1'b0;
                lane_byte = 8'h00;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state        <= RUN;
            bitbuf       <= 64'd0;
            bit_cnt      <= 7'd0;
            lane_cnt     <= 2'd0;
            word         <= 24'd0;
            flush_pend   <= 1'b0;
            dout_r       <= 32'd0;
            dout_valid_r <= 1'b0;
            flush_done_r <= 1'b0;
`ifdef BYTE_STUFF_EN
            stuff_pad    <= 1'b0;
`endif
        end else begin
            dout_valid_r <= 1'b0;
            flush_done_r <= 1'b0;

            if (lane_wr) begin
                lane_cnt <= lane_cnt + 2'd1;
                case (lane_cnt)
                    2'd0:    word[7:0]   <= lane_byte;
                    2'd1:    word[15:8]  <= lane_byte;
                    2'd2:    word[23:16] <= lane_byte;
                    default: begin
                        dout_r       <= {lane_byte, word};
                        dout_valid_r <= 1'b1;
                    end
                endcase
            end

            case (state)
                RUN: begin
                    bitbuf  <= buf_next;
                    bit_cnt <= cnt_next;
                    if (flush_acc) flush_pend <= 1'b1;
`ifdef BYTE_STUFF_EN
                    if (extract && bitbuf[63:56] == 8'hFF) begin
                        state     <= STUFF;
                        stuff_pad <= 1'b0;
                    end else
`endif
                    // A flush accepted alongside a non-empty code waits a cycle so the code is padded too.
                    if (!extract && pend_eff && len_eff == 7'd0) begin
                        if (bit_cnt != 7'd0)       state <= PAD_BYTE;
                        else if (lane_cnt != 2'd0) state <= PAD_WORD;
                        else                       state <= DONE;
                    end
                end
`ifdef BYTE_STUFF_EN
                STUFF: begin
                    if (!stuff_pad)             state <= RUN;
                    else if (lane_cnt == 2'd3)  state <= DONE;
                    else                        state <= PAD_WORD;
                end
`endif
                PAD_BYTE: begin
                    bitbuf  <= 64'd0;
                    bit_cnt <= 7'd0;
`ifdef BYTE_STUFF_EN
                    if (pad_byte == 8'hFF) begin
                        state     <= STUFF;
                        stuff_pad <= 1'b1;
                    end else
`endif
                    if (lane_cnt == 2'd3) state <= DONE;
                    else                  state <= PAD_WORD;
                end
                PAD_WORD: begin
                    if (lane_cnt == 2'd3) state <= DONE;
                end
                DONE: begin
                    flush_done_r <= 1'b1;
                    flush_pend   <= 1'b0;
                    state        <= RUN;
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_huff_bit_packer.sv
// tb/tb_huff_bit_packer.sv - randomized self-checking bench for huff_bit_packer against a bit-queue model
module tb_huff_bit_packer;
    localparam int CODE_W = 27;

    logic clk = 1'b0;
    logic nrst = 1'b0;
    always #5 clk = ~clk;

    huff_bit_packer_if #(.CODE_W(CODE_W)) bus();
    huff_bit_packer #(.CODE_W(CODE_W)) dut (.clk(clk), .nrst(nrst), .bus(bus));

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_dv = -100;
    int last_fd = -100;
    int min_gap = 1000;
    int fd_cnt = 0;
    int stall_cnt = 0;

    logic [31:0] got[$];
    logic [31:0] exp_w[$];
    bit          mbits[$];
    logic [7:0]  macc[$];

    always @(negedge clk) begin
        cyc++;
        if (nrst && bus.dout_valid) begin
            got.push_back(bus.dout);
            if (cyc - last_dv < min_gap) min_gap = cyc - last_dv;
            last_dv = cyc;
        end
        if (nrst && bus.flush_done) begin
            fd_cnt++;
            last_fd = cyc;
        end
    end

    // Reference: stream of bits -> bytes (stuffing) -> little-endian words.
    function automatic void m_put(logic [7:0] b);
        macc.push_back(b);
        if (macc.size() == 4) begin
            exp_w.push_back({macc[3], macc[2], macc[1], macc[0]});
            macc.delete();
        end
    endfunction

    function automatic void m_byte(logic [7:0] b);
        m_put(b);
`ifdef BYTE_STUFF_EN
        if (b == 8'hFF) m_put(8'h00);
`endif
    endfunction

    function automatic void m_add(logic [31:0] code, int len);
        logic [7:0] b;
        for (int i = len - 1; i >= 0; i--) mbits.push_back(code[i]);
        while (mbits.size() >= 8) begin
            b = 8'h00;
            for (int k = 0; k < 8; k++) b = {b[6:0], mbits.pop_front()};
            m_byte(b);
        end
    endfunction

    function automatic void m_flush();
        logic [7:0] b;
        if (mbits.size() > 0) begin
            b = 8'hFF;
            for (int k = 0; k < mbits.size(); k++) b[7-k] = mbits[k];
            mbits.delete();
            m_byte(b);
        end
        while (macc.size() != 0) m_put(8'hFF);
    endfunction

    function automatic void clear_all();
        got.delete();
        exp_w.delete();
        mbits.delete();
        macc.delete();
        min_gap = 1000;
        stall_cnt = 0;
    endfunction

    task automatic handshake();
        bit ok;
        bit rdy;
        ok = 1'b0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            rdy = bus.in_ready;
            if (!rdy) stall_cnt++;
            @(posedge clk);
            #1;
            if (rdy) begin
                ok = 1'b1;
                break;
            end
        end
        bus.in_valid = 1'b0;
        bus.flush = 1'b0;
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL handshake_timeout got in_ready=0 for 300 cycles, need accept");
        end
    endtask

    task automatic send(input logic [31:0] code, input int len, input bit fl);
        bus.in_code = code[CODE_W-1:0];
        bus.in_len = 6'(len);
        bus.in_valid = 1'b1;
        bus.flush = fl;
        handshake();
        m_add(code, len);
        if (fl) m_flush();
    endtask

    task automatic flush_req();
        bus.flush = 1'b1;
        handshake();
        m_flush();
    endtask

    task automatic wait_done();
        int start;
        int n;
        start = fd_cnt;
        n = 0;
        while (fd_cnt == start && n < 400) begin
            @(posedge clk);
            n++;
        end
        #1;
        checks++;
        if (fd_cnt == start) begin
            failures++;
            $display("FAIL flush_done_timeout got none need pulse");
        end
        repeat (2) begin @(posedge clk); #1; end
    endtask

    task automatic test_reset();
        bus.in_code = '0;
        bus.in_len = 6'd0;
        bus.in_valid = 1'b0;
        bus.flush = 1'b0;
        repeat (2) @(negedge clk);
        checks += 4;
        if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b need=1", bus.in_ready); end
        if (bus.dout !== 32'd0) begin failures++; $display("FAIL reset_dout got=%h need=0", bus.dout); end
        if (bus.dout_valid !== 1'b0) begin failures++; $display("FAIL reset_dout_valid got=%b need=0", bus.dout_valid); end
        if (bus.flush_done !== 1'b0) begin failures++; $display("FAIL reset_flush_done got=%b need=0", bus.flush_done); end
        @(posedge clk);
        #1 nrst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        clear_all();
        send(32'h12, 8, 0);
        send(32'h34, 8, 0);
        send(32'h56, 8, 0);
        send(32'h78, 8, 0);
        repeat (8) begin @(posedge clk); #1; end
        checks += 2;
        if (got.size() !== 1) begin failures++; $display("FAIL basic_count got=%0d need=1", got.size()); end
        else if (got[0] !== 32'h78563412) begin failures++; $display("FAIL basic_word got=%h need=78563412", got[0]); end
        flush_req();
        wait_done();
        checks++;
        if (got.size() !== 1) begin failures++; $display("FAIL basic_aligned_flush got=%0d words need=1", got.size()); end
    endtask

    task automatic test_stuff();
        logic [31:0] need;
        clear_all();
        send(32'hFF, 8, 0);
        send(32'h01, 8, 0);
        send(32'h02, 8, 0);
`ifdef BYTE_STUFF_EN
        need = 32'h020100FF;
`else
        send(32'h03, 8, 0);
        need = 32'h030201FF;
`endif
        repeat (8) begin @(posedge clk); #1; end
        checks += 2;
        if (got.size() !== 1) begin failures++; $display("FAIL stuff_count got=%0d need=1", got.size()); end
        else if (got[0] !== need) begin failures++; $display("FAIL stuff_word got=%h need=%h", got[0], need); end
        checks++;
        if (exp_w.size() !== 1 || exp_w[0] !== got[0]) begin failures++; $display("FAIL stuff_model got=%h need model", got[0]); end
        flush_req();
        wait_done();
    endtask

    task automatic test_flush_pad();
        clear_all();
        send(32'h5, 3, 0);
        flush_req();
        wait_done();
        checks += 3;
        if (got.size() !== 1) begin failures++; $display("FAIL pad_count got=%0d need=1", got.size()); end
        else if (got[0] !== 32'hFFFFFFBF) begin failures++; $display("FAIL pad_word got=%h need=FFFFFFBF", got[0]); end
        if (last_fd - last_dv !== 1) begin failures++; $display("FAIL pad_done_delay got=%0d need=1", last_fd - last_dv); end
    endtask

    task automatic test_pad_stuff();
        logic [31:0] need;
`ifdef BYTE_STUFF_EN
        need = 32'hFFFF00FF;
`else
        need = 32'hFFFFFFFF;
`endif
        clear_all();
        send(32'h1, 1, 0);
        flush_req();
        wait_done();
        checks += 2;
        if (got.size() !== 1) begin failures++; $display("FAIL padstuff_count got=%0d need=1", got.size()); end
        else if (got[0] !== need) begin failures++; $display("FAIL padstuff_word got=%h need=%h", got[0], need); end
    endtask

    task automatic test_empty_flush();
        int n;
        clear_all();
        flush_req();
        n = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n++;
            if (bus.flush_done) break;
        end
        checks += 2;
        if (n !== 2) begin failures++; $display("FAIL empty_flush_delay got=%0d need=2", n); end
        if (got.size() !== 0) begin failures++; $display("FAIL empty_flush_words got=%0d need=0", got.size()); end
        repeat (2) begin @(posedge clk); #1; end
    endtask

    task automatic test_code_with_flush();
        clear_all();
        for (int r = 0; r < 6; r++) begin
            send($urandom, $urandom_range(1, CODE_W), 1);
            wait_done();
        end
        checks++;
        if (got.size() !== exp_w.size()) begin failures++; $display("FAIL codeflush_count got=%0d need=%0d", got.size(), exp_w.size()); end
        else foreach (got[i]) begin
            checks++;
            if (got[i] !== exp_w[i]) begin failures++; $display("FAIL codeflush_word%0d got=%h need=%h", i, got[i], exp_w[i]); end
        end
    endtask

    task automatic test_random();
        clear_all();
        for (int r = 0; r < 80; r++) begin
            if ($urandom_range(3) == 0) repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
            if ($urandom_range(5) == 0) send(32'hFFFFFFFF, $urandom_range(0, CODE_W), 0);
            else send($urandom, $urandom_range(0, CODE_W), 0);
        end
        flush_req();
        wait_done();
        checks += 2;
        if (min_gap < 4) begin failures++; $display("FAIL random_gap got=%0d need>=4", min_gap); end
        if (got.size() !== exp_w.size()) begin failures++; $display("FAIL random_count got=%0d need=%0d", got.size(), exp_w.size()); end
        else foreach (got[i]) begin
            checks++;
            if (got[i] !== exp_w[i]) begin failures++; $display("FAIL random_word%0d got=%h need=%h", i, got[i], exp_w[i]); end
        end
    endtask

    task automatic test_back_to_back();
        clear_all();
        for (int r = 0; r < 40; r++) send($urandom, CODE_W, 0);
        flush_req();
        wait_done();
        checks += 3;
        if (stall_cnt == 0) begin failures++; $display("FAIL b2b_stall got=0 need>0"); end
        if (min_gap < 4) begin failures++; $display("FAIL b2b_gap got=%0d need>=4", min_gap); end
        if (got.size() !== exp_w.size()) begin failures++; $display("FAIL b2b_count got=%0d need=%0d", got.size(), exp_w.size()); end
        else foreach (got[i]) begin
            checks++;
            if (got[i] !== exp_w[i]) begin failures++; $display("FAIL b2b_word%0d got=%h need=%h", i, got[i], exp_w[i]); end
        end
    endtask

    task automatic test_reset_mid();
        clear_all();
        send(32'hAA, 8, 0);
        send(32'hBB, 8, 0);
        send(32'hABCDE, 20, 0);
        nrst = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        nrst = 1'b1;
        @(negedge clk);
        checks += 3;
        if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL rstmid_in_ready got=%b need=1", bus.in_ready); end
        if (bus.dout_valid !== 1'b0) begin failures++; $display("FAIL rstmid_dout_valid got=%b need=0", bus.dout_valid); end
        if (got.size() !== 0) begin failures++; $display("FAIL rstmid_words got=%0d need=0", got.size()); end
        @(posedge clk);
        #1;
        clear_all();
        send(32'h11, 8, 0);
        send(32'h22, 8, 0);
        send(32'h33, 8, 0);
        send(32'h44, 8, 0);
        repeat (8) begin @(posedge clk); #1; end
        checks += 2;
        if (got.size() !== 1) begin failures++; $display("FAIL rstmid_count got=%0d need=1", got.size()); end
        else if (got[0] !== 32'h44332211) begin failures++; $display("FAIL rstmid_word got=%h need=44332211", got[0]); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stuff();
        test_flush_pad();
        test_pad_stuff();
        test_empty_flush();
        test_code_with_flush();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
